ascii_msg_sequencer: RTL and testbench

Controller that plays a fixed 16-entry ASCII message ROM onto an 8-bit character bus, one character per valid/ack handshake. It supports programmable inter-character pacing and one-shot or looping playback, and it stops at a NUL terminator. The sequencer replaces the free-running ROM counter in the Tiny Tapeout top level. That wrapper drives `start`, `loop_en` and `pace` from `ui_in`, maps `char_out` to `uo_out`, and uses `uio` for the handshake.

---
 rtl/ascii_msg_pkg.sv | 21 ++
 rtl/msg_rom.sv | 13 +
 rtl/ascii_msg_sequencer.sv | 109 ++++++++++
 tb/tb_ascii_msg_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascii_msg_pkg.sv
// rtl/ascii_msg_pkg.sv - shared state type, constants and message text for the ASCII message sequencer
package ascii_msg_pkg;

  localparam int MSG_DEPTH = 16;

  localparam logic [7:0] NUL_CHAR = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_PRESENT,
    ST_PACE
  } seq_state_t;

  // "siliconpr0n.org" followed by the terminator
  localparam logic [7:0] MSG_TEXT [MSG_DEPTH] = '{
    8'h73, 8'h69, 8'h6C, 8'h69, 8'h63, 8'h6F, 8'h6E, 8'h70,
    8'h72, 8'h30, 8'h6E, 8'h2E, 8'h6F, 8'h72, 8'h67, 8'h00
  };

endpackage

// File: rtl/msg_rom.sv
// rtl/msg_rom.sv - combinational message ROM filled from the package text
module msg_rom
  import ascii_msg_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [7:0]        data
);

  assign data = MSG_TEXT[addr];

endmodule

// File: rtl/ascii_msg_sequencer.sv
// rtl/ascii_msg_sequencer.sv - plays the message ROM onto a valid/ack character bus with pacing and looping
module ascii_msg_sequencer
  import ascii_msg_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int PACE_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  input  logic              loop_en,
  input  logic [PACE_W-1:0] pace,
  input  logic              char_ack,
  output logic [7:0]        char_out,
  output logic              char_valid,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] index
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  seq_state_t        state;
  logic [PACE_W-1:0] pace_cnt;
  logic [7:0]        rom_data;
  logic              loop_restart;

  msg_rom #(
    .ADDR_W(ADDR_W)
  ) u_rom (
    .addr(index),
    .data(rom_data)
  );

  // A terminator at index 0 must finish, otherwise looping would spin forever on an empty message
  assign loop_restart = loop_en && (index != '0);
  assign busy         = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      index      <= '0;
      char_out   <= NUL_CHAR;
      char_valid <= 1'b0;
      done       <= 1'b0;
      pace_cnt   <= '0;
    end else begin
      done <= 1'b0;
      if (!ena) begin
        state      <= ST_IDLE;
        char_valid <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              index <= '0;
              state <= ST_FETCH;
            end
          end
          ST_FETCH: begin
            if (rom_data != NUL_CHAR) begin
              char_out   <= rom_data;
              char_valid <= 1'b1;
              state      <= ST_PRESENT;
            end else if (loop_restart) begin
              index <= '0;
              state <= ST_FETCH;
            end else begin
              done  <= 1'b1;
              state <= ST_IDLE;
            end
          end
          ST_PRESENT: begin
            if (char_ack) begin
              char_valid <= 1'b0;
              if (index == LAST_IDX) begin
                if (loop_restart) begin
                  index <= '0;
                  state <= ST_FETCH;
                end else begin
                  done  <= 1'b1;
                  state <= ST_IDLE;
                end
              end else begin
                index <= index + 1'b1;
                if (pace != '0) begin
                  pace_cnt <= pace;
                  state    <= ST_PACE;
                end else begin
                  state <= ST_FETCH;
                end
              end
            end
          end
          ST_PACE: begin
            pace_cnt <= pace_cnt - 1'b1;
            if (pace_cnt == PACE_W'(1)) begin
              state <= ST_FETCH;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ascii_msg_sequencer.sv
// tb/tb_ascii_msg_sequencer.sv - scoreboard bench for the ASCII message sequencer
module tb_ascii_msg_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       start = 1'b0;
  logic       loop_en = 1'b0;
  logic [3:0] pace = 4'd0;
  logic       char_ack = 1'b0;
  logic [7:0] char_out;
  logic       char_valid;
  logic       busy;
  logic       done;
  logic [3:0] index;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  // bit 8 set marks an expected done pulse, otherwise the low byte is an expected character
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;

  logic [7:0] msg [15] = '{
    8'h73, 8'h69, 8'h6C, 8'h69, 8'h63, 8'h6F, 8'h6E, 8'h70,
    8'h72, 8'h30, 8'h6E, 8'h2E, 8'h6F, 8'h72, 8'h67
  };

  ascii_msg_sequencer #(
    .DEPTH(16),
    .ADDR_W(4),
    .PACE_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .start(start),
    .loop_en(loop_en),
    .pace(pace),
    .char_ack(char_ack),
    .char_out(char_out),
    .char_valid(char_valid),
    .busy(busy),
    .done(done),
    .index(index)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (char_valid && char_ack) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_char unexpected: actual=%02h required=nothing", char_out);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e != {1'b0, char_out}) begin
            errors++;
            $display("FAIL sb_char: actual=char %02h required=%03h", char_out, mon_e);
          end
        end
      end
      if (done) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_done unexpected: actual=done required=nothing");
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e != 9'h100) begin
            errors++;
            $display("FAIL sb_done: actual=done required=%03h", mon_e);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_msg();
    for (int i = 0; i < 15; i++) exp_q.push_back({1'b0, msg[i]});
  endtask

  task automatic wait_done(input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < max);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_done timeout: actual=no done required=done within %0d cycles", max);
    end
  endtask

  task automatic wait_rise(output int at);
    logic pv;
    bit   found;
    pv = char_valid;
    found = 0;
    at = -1;
    for (int n = 0; n < 60 && !found; n++) begin
      tick();
      if (char_valid && !pv) begin
        found = 1;
        at = cyc_cnt;
      end
      pv = char_valid;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL wait_rise timeout: actual=no rise required=char_valid rise");
    end
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!char_valid && n < 60) begin
      tick();
      n++;
    end
    if (!char_valid) begin
      checks++;
      errors++;
      $display("FAIL wait_valid timeout: actual=0 required=1");
    end
  endtask

  task automatic ack_one();
    wait_valid();
    char_ack = 1'b1;
    tick();
    char_ack = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int t0;
    int t1;
    int t2;
    int stable;

    // reset state
    repeat (3) tick();
    check("reset_char_out", char_out, 8'h00);
    check("reset_char_valid", char_valid, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_index", index, 4'd0);
    rst_n = 1'b1;
    ena = 1'b1;
    tick();

    // one-shot, pace 0, ack held high
    char_ack = 1'b1;
    push_msg();
    exp_q.push_back(9'h100);
    start_pulse();
    wait_done(100, n);
    check("oneshot_done_latency", n, 31);
    tick();
    check("oneshot_done_single", done, 1'b0);
    check("oneshot_busy_after", busy, 1'b0);
    check("oneshot_sb_empty", exp_q.size(), 0);

    // pace 3 then lowered to 1 mid-message
    pace = 4'd3;
    push_msg();
    exp_q.push_back(9'h100);
    start_pulse();
    wait_rise(t0);
    wait_rise(t1);
    check("pace3_period", t1 - t0, 5);
    pace = 4'd1;
    wait_rise(t2);
    check("pace1_period", t2 - t1, 3);
    wait_done(200, n);
    pace = 4'd0;
    tick();
    check("pace_sb_empty", exp_q.size(), 0);

    // withhold ack on 'c'
    char_ack = 1'b0;
    push_msg();
    exp_q.push_back(9'h100);
    start_pulse();
    for (int i = 0; i < 4; i++) ack_one();
    wait_valid();
    check("hold_char_c", char_out, 8'h63);
    check("hold_index4", index, 4'd4);
    stable = 0;
    repeat (10) begin
      tick();
      if (char_valid && char_out == 8'h63) stable++;
    end
    check("hold_stable_cycles", stable, 10);
    ack_one();
    wait_rise(t0);
    check("hold_next_char_o", char_out, 8'h6F);
    char_ack = 1'b1;
    wait_done(100, n);
    tick();
    check("hold_sb_empty", exp_q.size(), 0);

    // looping playback, then loop_en dropped
    loop_en = 1'b1;
    push_msg();
    push_msg();
    exp_q.push_back(9'h100);
    start_pulse();
    for (int i = 0; i < 16; i++) wait_rise(t0);
    check("loop_restart_char", char_out, 8'h73);
    check("loop_restart_index", index, 4'd0);
    loop_en = 1'b0;
    wait_done(100, n);
    tick();
    check("loop_busy_after", busy, 1'b0);
    check("loop_sb_empty", exp_q.size(), 0);

    // ena dropped in PRESENT, start ignored while busy
    char_ack = 1'b0;
    exp_q.push_back({1'b0, 8'h73});
    start_pulse();
    ack_one();
    wait_valid();
    start_pulse();
    check("busy_start_index", index, 4'd1);
    check("busy_start_char", char_out, 8'h69);
    check("busy_start_valid", char_valid, 1'b1);
    ena = 1'b0;
    tick();
    check("ena_low_valid", char_valid, 1'b0);
    check("ena_low_busy", busy, 1'b0);
    check("ena_low_done", done, 1'b0);
    repeat (3) tick();
    check("ena_low_index_hold", index, 4'd1);
    check("ena_low_busy_later", busy, 1'b0);
    ena = 1'b1;
    tick();
    check("ena_sb_empty", exp_q.size(), 0);

    // asynchronous reset while pacing
    pace = 4'd5;
    char_ack = 1'b1;
    exp_q.push_back({1'b0, 8'h73});
    start_pulse();
    wait_rise(t0);
    tick();
    check("pace_state_busy", busy, 1'b1);
    check("pace_state_valid", char_valid, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_char_out", char_out, 8'h00);
    check("async_rst_valid", char_valid, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_index", index, 4'd0);
    check("async_rst_done", done, 1'b0);
    tick();
    rst_n = 1'b1;
    pace = 4'd0;
    tick();
    push_msg();
    exp_q.push_back(9'h100);
    start_pulse();
    wait_rise(t0);
    check("after_rst_first_char", char_out, 8'h73);
    wait_done(100, n);
    tick();
    check("final_sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
